// File: rtl/mac_wb_pkg.sv
// Shared types and constants for the MAC result writeback block.
// The MAC pipeline depth sizes both the last-tag shadow and the flush bubble counter.
package mac_wb_pkg;

   localparam int PIPE_DEPTH = 4;
   localparam int WB_ADDR_W  = 10;
   localparam int WB_DATA_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } wb_state_t;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/mac_wb_fifo.sv
// Result FIFO with a registered head entry, so the write port sees flop outputs only.
// A push while full is dropped; the owner detects that condition from full.
module mac_wb_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_next;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // Head tracks the oldest entry; a push into an empty (or emptying) FIFO bypasses memory.
         if (pop_ok) begin
            if (count > (AW+1)'(1)) head <= mem[rd_next];
            else if (push_ok)       head <= push_data;
         end else if (push_ok && empty) begin
            head <= push_data;
         end
      end
   end

endmodule

// File: rtl/mac_result_writeback.sv
// Drain side of the 3-tap MAC: shadows the last tags, buffers final sums, writes them out
// and sequences flush bubbles. Build option MAC_WB_RELU_EN clamps negative results to zero.
module mac_result_writeback
   import mac_wb_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 16,
   parameter int ADDR_WIDTH   = 10,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    arst_n_in,
   input  logic                    mac_input_valid,
   input  logic                    mac_last,
   input  logic [OUTPUT_WIDTH-1:0] mac_out,
   input  logic [31:0]             mac_ch_out,
   input  logic                    flush_req,
   output logic                    stall,
   output logic                    flush_adv,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [OUTPUT_WIDTH-1:0] mem_wdata,
   output logic                    mem_written,
   output logic                    done,
   output logic                    overflow_err
);

   localparam int CW   = $clog2(FIFO_DEPTH);
   localparam int EW   = ADDR_WIDTH + OUTPUT_WIDTH;
   localparam int AC_W = $clog2(PIPE_DEPTH + 1);

   wb_state_t               state, state_n;
   logic [AC_W-1:0]         adv_cnt, adv_n;
   logic [PIPE_DEPTH-1:0]   last_sr;
   logic                    mac_push;
   logic                    mem_pop;
   logic [OUTPUT_WIDTH-1:0] store_data;
   logic [EW-1:0]           fifo_head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW:0]             fifo_count;
   logic                    unused_ch;

   assign unused_ch = ^mac_ch_out[31:ADDR_WIDTH];

   // The stage-4 register holds a final sum exactly when the oldest shadow tag reaches the top.
   assign mac_push = mac_input_valid & last_sr[PIPE_DEPTH-1];
   assign mem_pop  = mem_valid & mem_ready;

`ifdef MAC_WB_RELU_EN
   assign store_data = mac_out[OUTPUT_WIDTH-1] ? '0 : mac_out;
`else
   assign store_data = mac_out;
`endif

   mac_wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (arst_n_in),
      .push      (mac_push),
      .push_data ({mac_ch_out[ADDR_WIDTH-1:0], store_data}),
      .pop       (mem_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign stall     = (fifo_count == (CW+1)'(FIFO_DEPTH));
   assign mem_valid = ~fifo_empty;
   assign mem_addr  = fifo_head[EW-1:OUTPUT_WIDTH];
   assign mem_wdata = fifo_head[OUTPUT_WIDTH-1:0];

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         last_sr      <= '0;
         mem_written  <= 1'b0;
         overflow_err <= 1'b0;
         state        <= IDLE;
         adv_cnt      <= '0;
      end else begin
         if (mac_input_valid) last_sr <= {last_sr[PIPE_DEPTH-2:0], mac_last};
         mem_written <= mem_pop;
         if (mac_push && fifo_full) overflow_err <= 1'b1;
         state   <= state_n;
         adv_cnt <= adv_n;
      end
   end

   always_comb begin
      state_n   = state;
      adv_n     = adv_cnt;
      flush_adv = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (flush_req) begin
               state_n = DRAIN;
               adv_n   = AC_W'(PIPE_DEPTH);
            end else if (mac_input_valid) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (flush_req) begin
               state_n = DRAIN;
               adv_n   = AC_W'(PIPE_DEPTH);
            end
         end
         DRAIN: begin
            // Bubbles push in-flight tags out; done waits for the shadow and FIFO to empty.
            flush_adv = (adv_cnt != '0) & ~stall;
            if (flush_adv) adv_n = adv_cnt - 1'b1;
            if (adv_cnt == '0 && last_sr == '0 && fifo_empty) state_n = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (mac_input_valid) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
